// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage.
// Private HI/LO registers, one bit per cycle, HI/LO read back via MFHI/MFLO.
// Optional build macro MULDIV_DIV_EN adds the DIVU decode, the DIV state
// and the restoring-divide datapath. Without it DIVU is ignored.
//
// state | meaning
// IDLE  | waiting for a start; MFHI/MFLO serviced here
// MUL   | shift-add step, one multiplier bit per cycle
// DIV   | restoring-divide step, one quotient bit per cycle
// FIX   | sign correction of the 2*WIDTH product for MULT
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       Operation,
  input  logic [5:0]       Funct,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MD   = 3'b011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
`ifdef MULDIV_DIV_EN
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits becoming quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand magnitude or divisor, held for the whole operation.
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 sgn_q, sgn_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 is_md;
  logic                 st_mult;
  logic                 st_multu;
  logic                 rd_hi;
  logic                 rd_lo;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   fix_val;
`ifdef MULDIV_DIV_EN
  logic                 st_divu;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
`endif

  // Instruction decode and per-step datapath values.
  always_comb begin
    is_md    = (Operation == OP_MD);
    st_mult  = is_md && (Funct == F_MULT);
    st_multu = is_md && (Funct == F_MULTU);
    rd_hi    = !is_md && (Funct == F_MFHI) && !busy_q;
    rd_lo    = !is_md && (Funct == F_MFLO) && !busy_q;

    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude 2^(WIDTH-1), so no extra bit is needed.
    a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    fix_val  = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

`ifdef MULDIV_DIV_EN
    st_divu  = is_md && (Funct == F_DIVU);
    // A zero divisor never fails the trial subtract, so the quotient fills
    // with ones and the dividend shifts intact into the remainder.
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_next = div_diff[WIDTH]
             ? {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
             : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif
  end

  // Next-state, datapath update, HI/LO write-back and read-back mux.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (st_mult || st_multu) begin
          state_d = MUL;
          cnt_d   = CW'(WIDTH);
          sgn_d   = st_mult;
          neg_d   = st_mult && (a[WIDTH-1] ^ b[WIDTH-1]);
          opb_d   = st_mult ? a_mag : a;
          acc_d   = {{WIDTH{1'b0}}, (st_mult ? b_mag : b)};
        end
`ifdef MULDIV_DIV_EN
        else if (st_divu) begin
          state_d = DIV;
          cnt_d   = CW'(WIDTH);
          sgn_d   = 1'b0;
          neg_d   = 1'b0;
          opb_d   = b;
          acc_d   = {{WIDTH{1'b0}}, a};
        end
`endif
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (sgn_q) begin
            state_d = FIX;
          end else begin
            state_d = IDLE;
            hi_d    = mul_next[2*WIDTH-1:WIDTH];
            lo_d    = mul_next[WIDTH-1:0];
            done_d  = 1'b1;
          end
        end
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          hi_d    = div_next[2*WIDTH-1:WIDTH];
          lo_d    = div_next[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
`endif
      FIX: begin
        acc_d   = fix_val;
        hi_d    = fix_val[2*WIDTH-1:WIDTH];
        lo_d    = fix_val[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    // HI/LO are written at the completing edge, so during the done cycle
    // hi_q/lo_q already hold the new values and a read then sees them.
    if (rd_hi) begin
      result_d = hi_q;
    end else if (rd_lo) begin
      result_d = lo_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32). Stimulus pushes expected
// read-back values and expected busy lengths; monitors pop and compare.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  Operation = '0;
  logic [5:0]  Funct = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .Operation(Operation), .Funct(Funct),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  int          exp_len_q[$];
  bit          rd_pend = 1'b0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // An MFHI/MFLO accepted at this edge must show on result by the next negedge.
  always @(posedge clk)
    rd_pend <= reset && (Operation != 3'b011) && ((Funct == F_MFHI) || (Funct == F_MFLO)) && !busy;

  // Monitor: compare read-backs and busy-run lengths against the scoreboard.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check(rd_name_q.pop_front(), result, exp_rd_q.pop_front());
    end
    if (busy) begin
      busy_cnt++;
    end else if (done) begin
      if (exp_len_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else check("busy_len", busy_cnt, exp_len_q.pop_front());
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic idle_inputs();
    Operation = 3'b000;
    Funct     = 6'b000000;
    a         = '0;
    b         = '0;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    Operation = 3'b011;
    Funct     = f;
    a         = av;
    b         = bv;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Caller is at a negedge; the read is driven for exactly one cycle.
  task automatic mf(input logic [5:0] f, input logic [31:0] exp, input string name);
    Operation = 3'b000;
    Funct     = f;
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(name);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", result,      32'd0);
    reset = 1'b1;

    // MULTU all-ones, read LO in the done cycle.
    exp_len_q.push_back(32);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_ff");
    mf(F_MFLO, 32'h0000_0001, "multu_ff_lo_done_cycle");
    mf(F_MFHI, 32'hFFFF_FFFE, "multu_ff_hi");

    // MULT -3*5 with a stalled MFLO and an ignored MULTU mid-operation.
    exp_len_q.push_back(33);
    issue(F_MULT, 32'hFFFF_FFFD, 32'd5);
    repeat (3) @(negedge clk);
    Operation = 3'b000;
    Funct     = F_MFLO;
    @(negedge clk);
    idle_inputs();
    check("mflo_busy_hold", result, 32'hFFFF_FFFE);
    check("busy_mid_op", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    Operation = 3'b011;
    Funct     = F_MULTU;
    a         = 32'd2;
    b         = 32'd3;
    @(negedge clk);
    idle_inputs();
    wait_done("mult_neg");
    mf(F_MFHI, 32'hFFFF_FFFF, "mult_neg_hi");
    mf(F_MFLO, 32'hFFFF_FFF1, "mult_neg_lo");

    // MULT most-negative squared.
    exp_len_q.push_back(33);
    issue(F_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_minneg");
    mf(F_MFLO, 32'h0000_0000, "mult_minneg_lo");
    mf(F_MFHI, 32'h4000_0000, "mult_minneg_hi");

`ifdef MULDIV_DIV_EN
    exp_len_q.push_back(32);
    issue(F_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7");
    mf(F_MFHI, 32'd2,  "divu_100_7_hi");
    mf(F_MFLO, 32'd14, "divu_100_7_lo");
    exp_len_q.push_back(32);
    issue(F_DIVU, 32'h0000_1234, 32'd0);
    wait_done("divu_by0");
    mf(F_MFLO, 32'hFFFF_FFFF, "divu_by0_lo");
    mf(F_MFHI, 32'h0000_1234, "divu_by0_hi");
`else
    issue(F_DIVU, 32'd100, 32'd7);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("divu_off_busy", busy_seen, 32'd0);
    mf(F_MFLO, 32'h0000_0000, "divu_off_lo");
    mf(F_MFHI, 32'h4000_0000, "divu_off_hi");
`endif

    // Reset in the middle of MULTU 7*9.
    issue(F_MULTU, 32'd7, 32'd9);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_done",   32'(done), 32'd0);
    check("midrst_result", result,    32'd0);
    reset = 1'b1;
    mf(F_MFHI, 32'd0, "midrst_hi");
    mf(F_MFLO, 32'd0, "midrst_lo");

    exp_len_q.push_back(32);
    issue(F_MULTU, 32'd7, 32'd9);
    wait_done("multu_7_9");
    mf(F_MFHI, 32'd0,  "multu_7_9_hi");
    mf(F_MFLO, 32'd63, "multu_7_9_lo");

    repeat (3) @(negedge clk);
    check("rd_queue_drained",  exp_rd_q.size(),  32'd0);
    check("len_queue_drained", exp_len_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
